dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH, 256, number of 32-bit words in data memory; power of two, 16..1024.
REQ-002 Parameter: LATENCY, 3, BUSY cycles per access; legal range 1..15.
REQ-003 Port: clk_i  input  1  single clock; all state updates on posedge.
REQ-004 Port: rst_i  input  1  reset, asynchronous, active-high.
REQ-005 Port: MemRead_i  input  1  load request from the EX/MEM pipeline register.
REQ-006 Port: MemWrite_i  input  1  store request from the EX/MEM pipeline register.
REQ-007 Port: Addr_i  input  32  byte address (ALU result).
REQ-008 Port: WriteData_i  input  32  store data.
REQ-009 Port: ReadData_o  output  32  load result, registered.
REQ-010 Port: Stall_o  output  1  pipeline freeze request.
REQ-011 Port: Valid_o  output  1  one-cycle pulse: access completed.
REQ-012 Port: Err_o  output  1  one-cycle pulse: request rejected.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-014 Valid request: exactly one of MemRead_i/MemWrite_i high, and Addr_i[1:0]==2'b00.
REQ-015 In IDLE with a valid request, the block SHALL latch op, word index Addr_i[log2(DEPTH)+1:2], and WriteData_i, load the 4-bit counter with LATENCY-1, and go to BUSY.
REQ-016 Address bits above log2(DEPTH)+1 SHALL be ignored, so addresses wrap modulo DEPTH words.
REQ-017 Stall_o SHALL be combinationally high in IDLE while a valid request is present, and high in every BUSY cycle.
REQ-018 Stall_o SHALL be low in DONE and in IDLE with no valid request.
REQ-019 Total stall per access SHALL be LATENCY+1 cycles.
REQ-020 In BUSY with counter non-zero, the counter SHALL decrement.
REQ-021 In BUSY with counter zero, the latched access SHALL be performed at that edge and the FSM SHALL go to DONE.
REQ-022 A load SHALL update ReadData_o with mem[index] at the access edge.
REQ-023 A store SHALL write mem[index] at the access edge and SHALL leave ReadData_o unchanged.
REQ-024 Valid_o SHALL be high exactly in the DONE cycle.
REQ-025 DONE SHALL go to IDLE unconditionally after one cycle.
REQ-026 Request inputs SHALL be ignored in DONE; the pipeline advances on that edge.
REQ-027 Inputs SHALL be ignored in BUSY; the access uses only the latched values.
REQ-028 ReadData_o SHALL hold its value until the next completed load.
REQ-029 In IDLE, if MemRead_i and MemWrite_i are both high, or an op is high with Addr_i[1:0]!=0: Err_o SHALL pulse for one cycle, no access SHALL occur, Stall_o SHALL stay low, and the FSM SHALL stay in IDLE.
REQ-030 A request that stays invalid SHALL pulse Err_o every IDLE cycle.
REQ-031 A load issued in the IDLE cycle right after a store's DONE SHALL return the newly stored data.

Reset
REQ-032 rst_i high SHALL immediately force: state=IDLE, counter=0, ReadData_o=0, Valid_o=0, Err_o=0.
REQ-033 Stall_o during reset SHALL equal its IDLE combinational value.
REQ-034 Reset during BUSY SHALL abort the access; a pending store SHALL NOT be committed.
REQ-035 Memory array contents SHALL NOT be affected by reset; array is zero-initialized for simulation only.

Verification
REQ-036 LATENCY=3: store 0xDEADBEEF to 0x10, hold inputs while Stall_o high -> Stall_o high 4 cycles, Valid_o pulses in cycle 5, ReadData_o unchanged.
REQ-037 Load 0x10 issued in the IDLE cycle right after the store's DONE -> ReadData_o=0xDEADBEEF at the access edge, Valid_o pulse 4 cycles after issue.
REQ-038 Load 0x12 (misaligned), then both MemRead_i and MemWrite_i high at 0x20 -> each gives one Err_o pulse, Stall_o never high, ReadData_o and memory unchanged.
REQ-039 DEPTH=256: store 0x12345678 to 0x400, then load 0x000 -> returns 0x12345678 (wrap).
REQ-040 Store 0xAAAA5555 to 0x08, rst_i pulsed in 2nd BUSY cycle, then load 0x08 -> returns previous contents (0), not 0xAAAA5555; outputs zero during reset.
REQ-041 LATENCY=1: back-to-back loads -> each stalls 2 cycles, Valid_o pulses every 3rd cycle.

Source files
------------

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - EX/MEM data-memory request/response bundle
interface dmem_responder_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic [31:0] ReadData_o;
    logic        Stall_o;
    logic        Valid_o;
    logic        Err_o;

    modport master (
        output MemRead_i, MemWrite_i, Addr_i, WriteData_i,
        input  ReadData_o, Stall_o, Valid_o, Err_o
    );

    modport slave (
        input  MemRead_i, MemWrite_i, Addr_i, WriteData_i,
        output ReadData_o, Stall_o, Valid_o, Err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data memory with pipeline stall handshake
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           op_wr_q, op_wr_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           mem_we;
    logic           req_any;
    logic           req_valid;
    logic           unused_addr;

    logic [31:0]    mem [DEPTH] = '{default: '0};

    // Upper address bits are dropped so accesses wrap modulo DEPTH words.
    assign unused_addr = ^{bus.Addr_i[31:AW+2]};

    assign req_any   = bus.MemRead_i | bus.MemWrite_i;
    assign req_valid = (bus.MemRead_i ^ bus.MemWrite_i) && (bus.Addr_i[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_wr_d = bus.MemWrite_i;
                    idx_d   = bus.Addr_i[AW+1:2];
                    wdata_d = bus.WriteData_i;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = BUSY;
                end else if (req_any) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx_q];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array has no reset; an aborted store never reaches here since reset clears BUSY.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.Stall_o    = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
    assign bus.Valid_o    = (state_q == DONE);
    assign bus.Err_o      = err_q;
    assign bus.ReadData_o = rdata_q;
endmodule
